yarp_mem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single shared memory port of the yarp core. It multiplexes instruction fetch and load/store traffic onto one request/grant/response memory interface and allows one outstanding transaction at a time. It returns each response to the requester that issued it, and converts a missing response into an error after a bounded wait. Raw read data is returned unmodified; load sign/zero extension happens downstream.

---
 rtl/yarp_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_yarp_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/yarp_mem_arbiter.sv
// yarp_mem_arbiter
// Shares the single memory port of the yarp core between instruction fetch
// and load/store traffic. Only one transaction is in flight at a time. Each
// response goes back to the requester that issued it. A response that never
// arrives is turned into an error after a bounded wait.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   instr_req_i/addr_i         fetch request (always a WORD read)
//   instr_gnt/rvalid/rdata/err fetch handshake and response
//   data_req/addr/byte_en/wr/wr_data_i   load/store request
//   data_gnt/rvalid/rdata/err  load/store handshake and response
//   mem_req/addr/byte_en/wr/wr_data_o    registered memory request
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i memory handshake and response
module yarp_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic [1:0]  data_byte_en_i,
  input  logic        data_wr_i,
  input  logic [31:0] data_wr_data_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [1:0]  mem_byte_en_o,
  output logic        mem_wr_o,
  output logic [31:0] mem_wr_data_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  // mem_access_size_e encodings
  localparam logic [1:0] BYTE      = 2'b00;
  localparam logic [1:0] HALF_WORD = 2'b01;
  localparam logic [1:0] WORD      = 2'b11;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_e;

  state_e        state_reg;
  logic          sel_reg;     // 0 = fetch owns the port, 1 = data
  logic [SW-1:0] starve_reg;  // consecutive fetch losses to data
  logic [TW-1:0] tmo_reg;     // cycles spent waiting in RSP

  logic pick_instr;
  logic tmo_last;
  logic rsp_fire;
  logic req_gnt;

  // Data wins unless fetch has lost STARVE_LIMIT times in a row.
  assign pick_instr = instr_req_i && (!data_req_i || (starve_reg == STARVE_MAX));
  assign tmo_last   = (tmo_reg == TMO_LAST);
  assign req_gnt    = (state_reg == REQ) && mem_gnt_i;
  // A real response takes precedence over a timeout landing in the same cycle.
  assign rsp_fire   = (state_reg == RSP) && (mem_rvalid_i || tmo_last);

  assign mem_req_o      = (state_reg == REQ);

  assign instr_gnt_o    = req_gnt && !sel_reg;
  assign data_gnt_o     = req_gnt && sel_reg;

  assign instr_rvalid_o = rsp_fire && !sel_reg;
  assign instr_err_o    = instr_rvalid_o && !mem_rvalid_i;
  assign instr_rdata_o  = (instr_rvalid_o && mem_rvalid_i) ? mem_rdata_i : 32'h0;

  assign data_rvalid_o  = rsp_fire && sel_reg;
  assign data_err_o     = data_rvalid_o && !mem_rvalid_i;
  // Stores return no data, only the completion pulse.
  assign data_rdata_o   = (data_rvalid_o && mem_rvalid_i && !mem_wr_o) ? mem_rdata_i : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      sel_reg       <= 1'b0;
      starve_reg    <= '0;
      tmo_reg       <= '0;
      mem_addr_o    <= 32'h0;
      mem_byte_en_o <= BYTE;
      mem_wr_o      <= 1'b0;
      mem_wr_data_o <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (instr_req_i || data_req_i) begin
            state_reg <= REQ;
            if (pick_instr) begin
              sel_reg       <= 1'b0;
              starve_reg    <= '0;
              mem_addr_o    <= instr_addr_i;
              mem_byte_en_o <= WORD;
              mem_wr_o      <= 1'b0;
              mem_wr_data_o <= 32'h0;
            end else begin
              sel_reg       <= 1'b1;
              mem_addr_o    <= data_addr_i;
              mem_byte_en_o <= data_byte_en_i;
              mem_wr_o      <= data_wr_i;
              mem_wr_data_o <= data_wr_data_i;
              // Only a contested win counts against fetch; pick_instr forces
              // the fetch win at STARVE_MAX so this never overflows.
              if (instr_req_i) begin
                starve_reg <= starve_reg + SW'(1);
              end
            end
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            state_reg <= RSP;
            tmo_reg   <= '0;
          end
        end
        RSP: begin
          if (rsp_fire) begin
            state_reg <= IDLE;
          end else begin
            tmo_reg <= tmo_reg + TW'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_yarp_mem_arbiter.sv
// Directed bench for yarp_mem_arbiter: a table of single transactions plus
// hand-written sequences for starvation, timeout and reset-in-flight.
module tb_yarp_mem_arbiter;

  localparam logic [1:0] BYTE      = 2'b00;
  localparam logic [1:0] HALF_WORD = 2'b01;
  localparam logic [1:0] WORD      = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i;
  logic [31:0] data_addr_i;
  logic [1:0]  data_byte_en_i;
  logic        data_wr_i;
  logic [31:0] data_wr_data_i;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [1:0]  mem_byte_en_o;
  logic        mem_wr_o;
  logic [31:0] mem_wr_data_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  yarp_mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i),
    .data_byte_en_i(data_byte_en_i), .data_wr_i(data_wr_i),
    .data_wr_data_i(data_wr_data_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .data_err_o(data_err_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_byte_en_o(mem_byte_en_o), .mem_wr_o(mem_wr_o),
    .mem_wr_data_o(mem_wr_data_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  typedef struct {
    logic        is_data;
    logic [31:0] addr;
    logic [1:0]  be;
    logic        wr;
    logic [31:0] wdata;
    int          gnt_dly;
    int          rsp_dly;
    logic [31:0] mrdata;
    logic [1:0]  exp_be;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    instr_req_i = 0; instr_addr_i = 0;
    data_req_i = 0; data_addr_i = 0; data_byte_en_i = BYTE;
    data_wr_i = 0; data_wr_data_i = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic own_gnt, oth_gnt, own_rv, oth_rv, own_err;
    logic [31:0] own_rdata;
    @(negedge clk);
    if (v.is_data) begin
      data_req_i = 1; data_addr_i = v.addr; data_byte_en_i = v.be;
      data_wr_i = v.wr; data_wr_data_i = v.wdata;
    end else begin
      instr_req_i = 1; instr_addr_i = v.addr;
    end
    @(negedge clk);
    chk1("req_latency", mem_req_o, 1'b1);
    chk32("req_addr", mem_addr_o, v.addr);
    chk32("req_be", 32'(mem_byte_en_o), 32'(v.exp_be));
    chk1("req_wr", mem_wr_o, v.wr);
    chk32("req_wdata", mem_wr_data_o, v.wdata);
    for (int k = 0; k < v.gnt_dly; k++) begin
      #1;
      own_gnt = v.is_data ? data_gnt_o : instr_gnt_o;
      chk1("gnt_early", own_gnt, 1'b0);
      @(negedge clk);
      chk1("req_hold", mem_req_o, 1'b1);
      chk32("req_hold_addr", mem_addr_o, v.addr);
    end
    mem_gnt_i = 1;
    #1;
    own_gnt = v.is_data ? data_gnt_o : instr_gnt_o;
    oth_gnt = v.is_data ? instr_gnt_o : data_gnt_o;
    chk1("gnt_owner", own_gnt, 1'b1);
    chk1("gnt_other", oth_gnt, 1'b0);
    @(negedge clk);
    // Withdraw the request and scramble fields: the latched copy must win.
    mem_gnt_i = 0;
    instr_req_i = 0; instr_addr_i = 32'hFFFF_FFFF;
    data_req_i = 0; data_addr_i = 32'hFFFF_FFFF; data_wr_data_i = 32'hFFFF_FFFF;
    for (int k = 0; k < v.rsp_dly; k++) begin
      #1;
      own_rv = v.is_data ? data_rvalid_o : instr_rvalid_o;
      chk1("rvalid_early", own_rv, 1'b0);
      @(negedge clk);
    end
    mem_rvalid_i = 1; mem_rdata_i = v.mrdata;
    #1;
    own_rv    = v.is_data ? data_rvalid_o : instr_rvalid_o;
    oth_rv    = v.is_data ? instr_rvalid_o : data_rvalid_o;
    own_err   = v.is_data ? data_err_o : instr_err_o;
    own_rdata = v.is_data ? data_rdata_o : instr_rdata_o;
    chk1("rvalid_owner", own_rv, 1'b1);
    chk1("rvalid_other", oth_rv, 1'b0);
    chk1("rsp_err", own_err, 1'b0);
    chk32("rsp_rdata", own_rdata, v.exp_rdata);
    $display("txn %0d: %s addr=%h be=%b wr=%b rdata=%h", idx,
             v.is_data ? "data" : "instr", v.addr, v.exp_be, v.wr, own_rdata);
    @(negedge clk);
    mem_rvalid_i = 0; mem_rdata_i = 0;
    #1;
    own_rv = v.is_data ? data_rvalid_o : instr_rvalid_o;
    chk1("rvalid_pulse", own_rv, 1'b0);
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic seq[10];
    int got;
    int early;

    vecs[0] = '{1'b0, 32'h100, BYTE,      1'b0, 32'h0,    0, 0, 32'hDEADBEEF, WORD,      32'hDEADBEEF};
    vecs[1] = '{1'b1, 32'h200, HALF_WORD, 1'b1, 32'h1234, 3, 0, 32'h55AA55AA, HALF_WORD, 32'h0};
    vecs[2] = '{1'b1, 32'h304, BYTE,      1'b0, 32'h0,    1, 2, 32'h000000A5, BYTE,      32'h000000A5};
    vecs[3] = '{1'b1, 32'h400, WORD,      1'b0, 32'h0,    0, 5, 32'hCAFEF00D, WORD,      32'hCAFEF00D};
    vecs[4] = '{1'b0, 32'h104, BYTE,      1'b0, 32'h0,    2, 1, 32'h12345678, WORD,      32'h12345678};

    clear_inputs();
    reset = 1;
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_mem_req", mem_req_o, 1'b0);
    chk32("rst_mem_addr", mem_addr_o, 32'h0);
    chk32("rst_mem_be", 32'(mem_byte_en_o), 32'(BYTE));
    chk1("rst_mem_wr", mem_wr_o, 1'b0);
    chk32("rst_mem_wdata", mem_wr_data_o, 32'h0);
    chk32("rst_handshake", 32'({instr_gnt_o, instr_rvalid_o, instr_err_o,
                               data_gnt_o, data_rvalid_o, data_err_o}), 32'h0);
    chk32("rst_rdata", instr_rdata_o | data_rdata_o, 32'h0);
    reset = 0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Both requesters held continuously: expect D,D,D,D,I repeating.
    do_reset();
    instr_req_i = 1; instr_addr_i = 32'h900;
    data_req_i = 1; data_addr_i = 32'hA00; data_byte_en_i = WORD;
    mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h11;
    got = 0;
    for (int c = 0; c < 40 && got < 10; c++) begin
      @(negedge clk);
      #1;
      if (instr_gnt_o && data_gnt_o) chk1("gnt_exclusive", 1'b1, 1'b0);
      if (data_gnt_o) begin
        seq[got] = 1'b1; got++;
      end else if (instr_gnt_o) begin
        seq[got] = 1'b0; got++;
      end
    end
    chk32("starve_grants", 32'(got), 32'd10);
    for (int i = 0; i < got; i++) begin
      chk1("starve_order", seq[i], (i % 5 == 4) ? 1'b0 : 1'b1);
      $display("starve grant %0d: %s", i, seq[i] ? "D" : "I");
    end
    clear_inputs();

    // Load with no response: error after 64 RSP cycles, then a stray rvalid.
    do_reset();
    data_req_i = 1; data_addr_i = 32'h500; data_byte_en_i = WORD;
    @(negedge clk);
    mem_gnt_i = 1;
    #1;
    chk1("tmo_gnt", data_gnt_o, 1'b1);
    @(negedge clk);
    mem_gnt_i = 0; data_req_i = 0;
    early = 0;
    for (int k = 1; k < 64; k++) begin
      #1;
      if (data_rvalid_o) early++;
      @(negedge clk);
    end
    chk32("tmo_early", 32'(early), 32'd0);
    #1;
    chk1("tmo_rvalid", data_rvalid_o, 1'b1);
    chk1("tmo_err", data_err_o, 1'b1);
    chk32("tmo_rdata", data_rdata_o, 32'h0);
    chk1("tmo_instr_rvalid", instr_rvalid_o, 1'b0);
    $display("timeout txn: data_rvalid=%b err=%b", data_rvalid_o, data_err_o);
    @(negedge clk);
    mem_rvalid_i = 1; mem_rdata_i = 32'hBAD0BAD0;
    #1;
    chk1("stray_data_rvalid", data_rvalid_o, 1'b0);
    chk1("stray_instr_rvalid", instr_rvalid_o, 1'b0);
    chk32("stray_rdata", data_rdata_o, 32'h0);
    @(negedge clk);
    clear_inputs();

    // Reset during RSP of a fetch: the late response is dropped.
    @(negedge clk);
    instr_req_i = 1; instr_addr_i = 32'h700;
    @(negedge clk);
    mem_gnt_i = 1;
    #1;
    chk1("rrsp_gnt", instr_gnt_o, 1'b1);
    @(negedge clk);
    mem_gnt_i = 0; instr_req_i = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
    mem_rvalid_i = 1; mem_rdata_i = 32'hFFFF0000;
    #1;
    chk1("rrsp_rvalid", instr_rvalid_o, 1'b0);
    chk32("rrsp_rdata", instr_rdata_o, 32'h0);
    chk1("rrsp_mem_req", mem_req_o, 1'b0);
    chk32("rrsp_mem_addr", mem_addr_o, 32'h0);
    chk32("rrsp_mem_be", 32'(mem_byte_en_o), 32'(BYTE));
    @(negedge clk);
    #1;
    chk1("rrsp_rvalid_late", instr_rvalid_o, 1'b0);
    $display("reset-in-rsp txn: instr_rvalid=%b mem_req=%b", instr_rvalid_o, mem_req_o);
    clear_inputs();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
